// File: rtl/vga_sync_gen_if.sv
// Output bundle of vga_sync_gen: sync pulses, pixel tick, blanking and current coordinates.
interface vga_sync_gen_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;

    modport master (
        output hsync,
        output vsync,
        output video_on,
        output p_tick,
        output pixel_x,
        output pixel_y
    );

    modport slave (
        input hsync,
        input vsync,
        input video_on,
        input p_tick,
        input pixel_x,
        input pixel_y
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator: pixel-enable tick, active-low syncs, video_on and pixel coordinates.
// Optional macro VGA_FRAME_TICK_EN adds a registered one-clk frame_tick pulse after each frame wrap.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_RETRACE = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_RETRACE = 2,
    parameter int V_BACK    = 33,
    parameter int TICK_DIV  = 4
) (
    input  logic           clk,
    input  logic           reset,
`ifdef VGA_FRAME_TICK_EN
    output logic           frame_tick,
`endif
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;
    localparam int TICK_W  = $clog2(TICK_DIV);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              p_tick;
    logic [9:0]        h_count;
    logic [9:0]        v_count;
    logic [9:0]        h_next;
    logic [9:0]        v_next;
    logic              h_end;
    logic              v_end;
    logic              hsync_r;
    logic              vsync_r;

    // Pixel-enable divider: p_tick is decoded straight from the counter, no extra register.
    assign p_tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (p_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
        end
    end

    // Next-state coordinates; syncs are registered from these so they move with the counters.
    assign h_end = (h_count == H_LAST);
    assign v_end = (v_count == V_LAST);

    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (p_tick) begin
            h_next = h_end ? 10'd0 : h_count + 10'd1;
            if (h_end) begin
                v_next = v_end ? 10'd0 : v_count + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_count <= '0;
            v_count <= '0;
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
        end else begin
            h_count <= h_next;
            v_count <= v_next;
            hsync_r <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
            vsync_r <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
        end
    end

`ifdef VGA_FRAME_TICK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= p_tick && h_end && v_end;
        end
    end
`endif

    // Outputs: coordinates straight from the registers, blanking decoded from the same registers.
    assign vga.hsync    = hsync_r;
    assign vga.vsync    = vsync_r;
    assign vga.p_tick   = p_tick;
    assign vga.pixel_x  = h_count;
    assign vga.pixel_y  = v_count;
    assign vga.video_on = (h_count < H_VIS) && (v_count < V_VIS);
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for reset/line timing, shrunken instance for frame-level behaviour.
module tb_vga_sync_gen;
    typedef struct {int hd, hf, hr, hb, vd, vf, vr, vb, td;} tim_t;
    typedef struct {int x, y, hs, vs, vo, pt, ft;} exp_t;
    typedef struct {int n; int x, y, hs, vs, vo, pt;} vec_t;

    localparam int FRAME_B = 30 * 19 * 4;

    logic clk = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;
`ifdef VGA_FRAME_TICK_EN
    logic ft_a;
    logic ft_b;
`endif

    int errors = 0;
    int checks = 0;
    int n_a = 0;
    int n_b = 0;
    int cyc = 0;
    int hs_low_a = 0;
    bit count_hs = 0;
    int last_fall_b = -1;
    bit rst_seen_b = 1;
    logic vs_prev_b = 1'b1;
    tim_t tim_a;
    tim_t tim_b;
    vec_t vecs[14];

    always #5 clk = ~clk;

    vga_sync_gen_if bus_a ();
    vga_sync_gen_if bus_b ();

    vga_sync_gen dut_a (
        .clk(clk),
        .reset(reset_a),
`ifdef VGA_FRAME_TICK_EN
        .frame_tick(ft_a),
`endif
        .vga(bus_a)
    );

    vga_sync_gen #(
        .H_DISPLAY(16), .H_FRONT(4), .H_RETRACE(6), .H_BACK(4),
        .V_DISPLAY(12), .V_FRONT(2), .V_RETRACE(2), .V_BACK(3),
        .TICK_DIV(4)
    ) dut_b (
        .clk(clk),
        .reset(reset_b),
`ifdef VGA_FRAME_TICK_EN
        .frame_tick(ft_b),
`endif
        .vga(bus_b)
    );

    // Reference: everything follows from n = clk edges since reset release.
    function automatic exp_t model(tim_t t, int n);
        exp_t e;
        int ht, vt, frm, pix;
        ht   = t.hd + t.hf + t.hr + t.hb;
        vt   = t.vd + t.vf + t.vr + t.vb;
        frm  = ht * vt;
        pix  = (n / t.td) % frm;
        e.x  = pix % ht;
        e.y  = pix / ht;
        e.hs = (e.x >= t.hd + t.hf && e.x < t.hd + t.hf + t.hr) ? 0 : 1;
        e.vs = (e.y >= t.vd + t.vf && e.y < t.vd + t.vf + t.vr) ? 0 : 1;
        e.vo = (e.x < t.hd && e.y < t.vd) ? 1 : 0;
        e.pt = (n % t.td == t.td - 1) ? 1 : 0;
        e.ft = (n > 0 && n % t.td == 0 && (n / t.td) % frm == 0) ? 1 : 0;
        return e;
    endfunction

    function automatic int pack(int x, int y, int hs, int vs, int vo, int pt, int ft);
        return (ft << 24) | (x << 14) | (y << 4) | (hs << 3) | (vs << 2) | (vo << 1) | pt;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_cycle();
        exp_t ea, eb;
        int fa, fb;
        ea = model(tim_a, n_a);
        eb = model(tim_b, n_b);
`ifdef VGA_FRAME_TICK_EN
        fa = int'(ft_a);
        fb = int'(ft_b);
`else
        fa = 0;
        fb = 0;
        ea.ft = 0;
        eb.ft = 0;
`endif
        chk($sformatf("model_a n=%0d", n_a),
            pack(int'(bus_a.pixel_x), int'(bus_a.pixel_y), int'(bus_a.hsync), int'(bus_a.vsync),
                 int'(bus_a.video_on), int'(bus_a.p_tick), fa),
            pack(ea.x, ea.y, ea.hs, ea.vs, ea.vo, ea.pt, ea.ft));
        chk($sformatf("model_b n=%0d", n_b),
            pack(int'(bus_b.pixel_x), int'(bus_b.pixel_y), int'(bus_b.hsync), int'(bus_b.vsync),
                 int'(bus_b.video_on), int'(bus_b.p_tick), fb),
            pack(eb.x, eb.y, eb.hs, eb.vs, eb.vo, eb.pt, eb.ft));
        if (count_hs && bus_a.hsync == 1'b0) hs_low_a++;
        if (vs_prev_b == 1'b1 && bus_b.vsync == 1'b0) begin
            if (last_fall_b >= 0 && !rst_seen_b) chk("vsync_period_b", cyc - last_fall_b, FRAME_B);
            last_fall_b = cyc;
            rst_seen_b  = 0;
        end
        vs_prev_b = bus_b.vsync;
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_a) n_a = 0; else n_a++;
        if (!reset_b) begin
            n_b = 0;
            rst_seen_b = 1;
        end else begin
            n_b++;
        end
        cyc++;
        #1;
        check_cycle();
    endtask

    initial begin
        int guard;
        tim_a = '{640, 16, 96, 48, 480, 10, 2, 33, 4};
        tim_b = '{16, 4, 6, 4, 12, 2, 2, 3, 4};
        //           n     x    y hs vs vo pt
        vecs[0]  = '{1,     0,   0, 1, 1, 1, 0};
        vecs[1]  = '{3,     0,   0, 1, 1, 1, 1};
        vecs[2]  = '{4,     1,   0, 1, 1, 1, 0};
        vecs[3]  = '{7,     1,   0, 1, 1, 1, 1};
        vecs[4]  = '{2559,  639, 0, 1, 1, 1, 1};
        vecs[5]  = '{2560,  640, 0, 1, 1, 0, 0};
        vecs[6]  = '{2623,  655, 0, 1, 1, 0, 1};
        vecs[7]  = '{2624,  656, 0, 0, 1, 0, 0};
        vecs[8]  = '{3007,  751, 0, 0, 1, 0, 1};
        vecs[9]  = '{3008,  752, 0, 1, 1, 0, 0};
        vecs[10] = '{3199,  799, 0, 1, 1, 0, 1};
        vecs[11] = '{3200,  0,   1, 1, 1, 1, 0};
        vecs[12] = '{3203,  0,   1, 1, 1, 1, 1};
        vecs[13] = '{3204,  1,   1, 1, 1, 1, 0};

        // Power-up reset
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (5) step();
        chk("rst_x", int'(bus_a.pixel_x), 0);
        chk("rst_y", int'(bus_a.pixel_y), 0);
        chk("rst_hsync", int'(bus_a.hsync), 1);
        chk("rst_vsync", int'(bus_a.vsync), 1);
        chk("rst_p_tick", int'(bus_a.p_tick), 0);
        chk("rst_video_on", int'(bus_a.video_on), 1);
`ifdef VGA_FRAME_TICK_EN
        chk("rst_frame_tick", int'(ft_b), 0);
`endif
        reset_a = 1'b1;
        reset_b = 1'b1;

        // First line of the full-size timing, table-driven
        count_hs = 1;
        foreach (vecs[i]) begin
            while (n_a < vecs[i].n) step();
            chk($sformatf("vec%0d_x", i), int'(bus_a.pixel_x), vecs[i].x);
            chk($sformatf("vec%0d_y", i), int'(bus_a.pixel_y), vecs[i].y);
            chk($sformatf("vec%0d_hsync", i), int'(bus_a.hsync), vecs[i].hs);
            chk($sformatf("vec%0d_vsync", i), int'(bus_a.vsync), vecs[i].vs);
            chk($sformatf("vec%0d_video_on", i), int'(bus_a.video_on), vecs[i].vo);
            chk($sformatf("vec%0d_p_tick", i), int'(bus_a.p_tick), vecs[i].pt);
        end
        count_hs = 0;
        chk("hsync_low_clks", hs_low_a, 384);

        // Corner wrap (29,18) -> (0,0) on the small instance
        guard = 0;
        while (n_b % FRAME_B != FRAME_B - 1 && guard < 3000) begin
            step();
            guard++;
        end
        chk("corner_reach", n_b % FRAME_B, FRAME_B - 1);
        chk("corner_pre_x", int'(bus_b.pixel_x), 29);
        chk("corner_pre_y", int'(bus_b.pixel_y), 18);
        chk("corner_pre_p_tick", int'(bus_b.p_tick), 1);
        step();
        chk("corner_x", int'(bus_b.pixel_x), 0);
        chk("corner_y", int'(bus_b.pixel_y), 0);
        chk("corner_hsync", int'(bus_b.hsync), 1);
        chk("corner_vsync", int'(bus_b.vsync), 1);
        chk("corner_video_on", int'(bus_b.video_on), 1);
`ifdef VGA_FRAME_TICK_EN
        chk("corner_frame_tick", int'(ft_b), 1);
        step();
        chk("corner_frame_tick_end", int'(ft_b), 0);
`endif

        // Mid-frame reset at (10,8)
        guard = 0;
        while (n_b % FRAME_B != 4 * (8 * 30 + 10) && guard < 3000) begin
            step();
            guard++;
        end
        chk("mid_pre_x", int'(bus_b.pixel_x), 10);
        chk("mid_pre_y", int'(bus_b.pixel_y), 8);
        reset_b = 1'b0;
        step();
        reset_b = 1'b1;
        chk("mid_x", int'(bus_b.pixel_x), 0);
        chk("mid_y", int'(bus_b.pixel_y), 0);
        chk("mid_hsync", int'(bus_b.hsync), 1);
        chk("mid_vsync", int'(bus_b.vsync), 1);
        chk("mid_p_tick", int'(bus_b.p_tick), 0);
        repeat (2) step();
        chk("mid_p_tick_clk2", int'(bus_b.p_tick), 0);
        step();
        chk("mid_p_tick_clk3", int'(bus_b.p_tick), 1);
        repeat (4) step();
        chk("mid_p_tick_clk7", int'(bus_b.p_tick), 1);
        chk("mid_x_clk7", int'(bus_b.pixel_x), 1);

        // Random reset pulses against the reference model
        for (int i = 0; i < 8000; i++) begin
            if (reset_b == 1'b0) reset_b = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 1499) == 0) reset_b = 1'b0;
            if (reset_a == 1'b0) reset_a = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 2999) == 0) reset_a = 1'b0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA timing from the 100 MHz board clock.
- Produces a 25 MHz pixel-enable tick, active-low hsync/vsync, and video_on.
- Produces the current pixel coordinates pixel_x/pixel_y.
- Sits directly upstream of the text generator and the RGB output register, which consume video_on, pixel_x and pixel_y.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_RETRACE, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_RETRACE, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 4, clk cycles per pixel; must be >= 2

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-low reset
- hsync  out  1  horizontal sync, active low, registered
- vsync  out  1  vertical sync, active low, registered
- video_on  out  1  high while pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
- p_tick  out  1  one-clk pulse every TICK_DIV clks; pixel advance enable
- pixel_x  out  10  current column, 0..H_TOTAL-1
- pixel_y  out  10  current line, 0..V_TOTAL-1

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_RETRACE+H_BACK = 800
  - V_TOTAL = V_DISPLAY+V_FRONT+V_RETRACE+V_BACK = 525
- Reset:
  - Sampled on the rising clk edge only, when reset==0.
  - Loads: tick counter=0, h_count=0, v_count=0, hsync=1, vsync=1, p_tick=0.
  - Reset asserted mid-frame returns everything to these values on the next edge. No partial-line completion.
- Tick divider:
  - 2-bit (ceil log2 TICK_DIV) counter increments every clk and wraps TICK_DIV-1 -> 0.
  - p_tick = (counter == TICK_DIV-1), combinational from the counter.
  - After reset release (first edge with reset==1, counter becomes 1), p_tick is first high in the 3rd clk. Thereafter it is high every 4th clk.
- Horizontal counter: advances only on edges where p_tick==1. h_count == H_TOTAL-1 wraps to 0; otherwise it increments by 1.
- Vertical counter: advances only on edges where p_tick==1 and h_count == H_TOTAL-1.
  - v_count == V_TOTAL-1 wraps to 0; otherwise it increments by 1.
  - Simultaneous h and v wrap at (799,524) -> (0,0) in one edge.
- Sync outputs:
  - Registered from the next-state counter values, so they change on the same edge as the counters. No 1-pixel skew.
  - hsync=0 iff next h_count in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_RETRACE-1] = [656,751]; else 1.
  - vsync=0 iff next v_count in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_RETRACE-1] = [490,491]; else 1.
- Coordinate and blanking outputs:
  - pixel_x=h_count, pixel_y=v_count, driven directly from the registers.
  - video_on is combinational from the registered counters. It is valid in the same cycle as pixel_x/pixel_y.
  - Downstream font ROM latency is absorbed downstream, not here.
- Counters are held between ticks. No glitches on the outputs between p_ticks except p_tick itself.
- Widths: counters are 10 bits; all compares are unsigned.

Optional Feature:
- Macro: VGA_FRAME_TICK_EN.
- When defined, adds output port frame_tick (out, 1).
  - frame_tick is a registered one-clk pulse, high in the clk immediately after the edge where the counters wrap (799,524) -> (0,0).
  - Coincident with pixel_x=0, pixel_y=0 becoming visible.
  - Reset value 0. Not asserted by reset itself.
- When undefined: no port, no extra logic; all other behaviour identical.

Test Plan:
- Reset check:
  - Stimulus: hold reset=0 for 5 clks.
  - Required: pixel_x=0, pixel_y=0, hsync=1, vsync=1, p_tick=0, video_on=1.
  - Then release and verify p_tick high in clk 3 after release, then exactly every 4 clks.
- Line timing:
  - Run 1 line.
  - Required: pixel_x steps 0..799 then 0, pixel_y 0 -> 1 at the wrap.
  - Required: hsync low for exactly 96 ticks (384 clks), first low when pixel_x=656, high again at pixel_x=752.
  - Required: video_on falls at pixel_x=640 and rises at pixel_x=0.
- Frame timing:
  - Run 2 frames.
  - Required: vsync low exactly while pixel_y in {490,491}.
  - Required: video_on=0 for all pixel_y >= 480.
  - Required: frame period = 800*525*4 = 1,680,000 clks between vsync falling edges.
- Corner wrap:
  - At (799,524) with p_tick high, next edge gives (0,0), hsync=1, vsync=1, video_on=1.
- Mid-frame reset:
  - Assert reset=0 for 1 clk at (300,200).
  - Required: next edge gives (0,0), hsync=1, vsync=1. Timing restarts as after power-up.
- Frame tick (VGA_FRAME_TICK_EN defined):
  - frame_tick is a single 1-clk pulse per frame, immediately after the (799,524) -> (0,0) edge.
  - Never asserted during or immediately after reset.
